// File: rtl/mips_pkg.sv
// Shared MIPS constants: opcodes, controller state codes, ALU control encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_READ  = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WRITE = 4'd5,
    ST_EXEC_R    = 4'd6,
    ST_WB_R      = 4'd7,
    ST_EXEC_I    = 4'd8,
    ST_WB_I      = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_OR    = 3'b011,
    ALU_AND   = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SL = 2'b11
  } alu_src_b_e;

  localparam logic [1:0] PCSRC_ALU     = 2'b00;
  localparam logic [1:0] PCSRC_ALU_OUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP    = 2'b10;

endpackage

// File: rtl/multicycle_output_decode.sv
// Combinational map from controller state (plus opcode/zero/ready) to datapath controls.
module multicycle_output_decode
  import mips_pkg::*;
(
  input  state_e      state_i,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic        reg_dst_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  pc_source_o,
  output logic        illegal_o
);

  // Per-state control values; everything defaults to 0.
  always_comb begin
    pc_write_o   = 1'b0;
    ir_write_o   = 1'b0;
    i_or_d_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_dst_o    = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = '0;
    alu_op_o     = '0;
    pc_source_o  = '0;
    illegal_o    = 1'b0;
    unique case (state_i)
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        alu_op_o    = ALU_ADD;
        pc_source_o = PCSRC_ALU;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      ST_DECODE: begin
        alu_src_b_o = SRCB_IMM_SL;
        alu_op_o    = ALU_ADD;
        unique case (opcode_i)
          OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI,
          OP_ANDI, OP_ORI, OP_LW, OP_SW: illegal_o = 1'b0;
          default:                       illegal_o = 1'b1;
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = ALU_ADD;
      end
      ST_MEM_READ: begin
        i_or_d_o   = 1'b1;
        mem_read_o = 1'b1;
      end
      ST_MEM_WRITE: begin
        i_or_d_o    = 1'b1;
        mem_write_o = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_B;
        alu_op_o    = ALU_FUNCT;
      end
      ST_WB_R: begin
        reg_write_o = 1'b1;
        reg_dst_o   = 1'b1;
      end
      ST_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        if (opcode_i == OP_ANDI)     alu_op_o = ALU_AND;
        else if (opcode_i == OP_ORI) alu_op_o = ALU_OR;
        else                         alu_op_o = ALU_ADD;
      end
      ST_WB_I: begin
        reg_write_o = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_B;
        alu_op_o    = ALU_SUB;
        pc_source_o = PCSRC_ALU_OUT;
        pc_write_o  = (opcode_i == OP_BNE) ? ~zero_i : zero_i;
      end
      ST_JUMP: begin
        pc_source_o = PCSRC_JUMP;
        pc_write_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller: state register, next-state logic, output decode.
module multicycle_control
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        ir_write_o,
  output logic        i_or_d_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o,
  output logic        reg_dst_o,
  output logic        reg_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [2:0]  alu_op_o,
  output logic [1:0]  pc_source_o,
  output logic [3:0]  state_o,
  output logic        illegal_o
);

  state_e state_q, state_d;
  logic   pc_write_raw, ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

  // State register with asynchronous abort to FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Next-state sequencing; memory states hold until mem_ready_i.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH:     if (mem_ready_i) state_d = ST_DECODE;
      ST_DECODE: begin
        unique case (opcode_i)
          OP_LW, OP_SW:             state_d = ST_MEM_ADDR;
          OP_RTYPE:                 state_d = ST_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = ST_EXEC_I;
          OP_BEQ, OP_BNE:           state_d = ST_BRANCH;
          OP_J:                     state_d = ST_JUMP;
          default:                  state_d = ST_FETCH;
        endcase
      end
      ST_MEM_ADDR:  state_d = (opcode_i == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready_i) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready_i) state_d = ST_FETCH;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_EXEC_R:    state_d = ST_WB_R;
      ST_WB_R:      state_d = ST_FETCH;
      ST_EXEC_I:    state_d = ST_WB_I;
      ST_WB_I:      state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  multicycle_output_decode u_decode (
    .state_i      (state_q),
    .opcode_i     (opcode_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_raw),
    .ir_write_o   (ir_write_raw),
    .i_or_d_o     (i_or_d_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_raw),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_dst_o    (reg_dst_o),
    .reg_write_o  (reg_write_raw),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .pc_source_o  (pc_source_o),
    .illegal_o    (illegal_raw)
  );

  // FETCH with mem_ready_i=1 would otherwise raise pc/ir write during reset,
  // so all write-type outputs are masked directly by the reset input.
  assign pc_write_o  = pc_write_raw  & ~reset;
  assign ir_write_o  = ir_write_raw  & ~reset;
  assign mem_write_o = mem_write_raw & ~reset;
  assign reg_write_o = reg_write_raw & ~reset;
  assign illegal_o   = illegal_raw   & ~reset;
  assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode_i;
  logic       zero_i;
  logic       mem_ready_i;
  logic       pc_write_o, ir_write_o, i_or_d_o, mem_read_o, mem_write_o;
  logic       mem_to_reg_o, reg_dst_o, reg_write_o, alu_src_a_o, illegal_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [2:0] alu_op_o;
  logic [3:0] state_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .opcode_i     (opcode_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .ir_write_o   (ir_write_o),
    .i_or_d_o     (i_or_d_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .reg_dst_o    (reg_dst_o),
    .reg_write_o  (reg_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .pc_source_o  (pc_source_o),
    .state_o      (state_o),
    .illegal_o    (illegal_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and check the state entered.
  task automatic step_state(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    check(tag, {28'd0, state_o}, {28'd0, exp});
  endtask

  task automatic no_writes(input string tag);
    check(tag, {28'd0, pc_write_o, ir_write_o, reg_write_o, mem_write_o}, 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    opcode_i    = 6'h00;
    zero_i      = 1'b0;
    mem_ready_i = 1'b1;

    // Reset held: FETCH, write enables masked, FETCH mux values visible.
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {28'd0, state_o}, 32'd0);
    no_writes("rst_writes");
    check("rst_illegal", {31'd0, illegal_o}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read_o}, 32'd1);
    check("rst_srcb", {30'd0, alu_src_b_o}, 32'd1);

    // R-type: 0,1,6,7,0
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("r_fetch_irw", {30'd0, ir_write_o, pc_write_o}, 32'd3);
    check("r_fetch_regw", {31'd0, reg_write_o}, 32'd0);
    step_state("r_st1", 4'd1);
    check("r_dec_srcb", {30'd0, alu_src_b_o}, 32'd3);
    check("r_dec_regw", {31'd0, reg_write_o}, 32'd0);
    step_state("r_st6", 4'd6);
    check("r_exec_aluop", {29'd0, alu_op_o}, 32'd2);
    check("r_exec_regw", {31'd0, reg_write_o}, 32'd0);
    step_state("r_st7", 4'd7);
    check("r_wb_regw_dst", {30'd0, reg_write_o, reg_dst_o}, 32'd3);
    step_state("r_st0", 4'd0);
    check("r_back_regw", {31'd0, reg_write_o}, 32'd0);

    // FETCH wait state, then lw with two MEM_READ wait cycles.
    opcode_i    = 6'h23;
    mem_ready_i = 1'b0;
    #1;
    check("fw_writes", {30'd0, ir_write_o, pc_write_o}, 32'd0);
    check("fw_mem_read", {31'd0, mem_read_o}, 32'd1);
    step_state("fw_hold", 4'd0);
    mem_ready_i = 1'b1;
    step_state("lw_st1", 4'd1);
    step_state("lw_st2", 4'd2);
    check("lw_addr_srcb", {30'd0, alu_src_b_o}, 32'd2);
    mem_ready_i = 1'b0;
    step_state("lw_st3a", 4'd3);
    check("lw_rd_a", {30'd0, mem_read_o, i_or_d_o}, 32'd3);
    step_state("lw_st3b", 4'd3);
    check("lw_rd_b", {30'd0, mem_read_o, i_or_d_o}, 32'd3);
    step_state("lw_st3c", 4'd3);
    mem_ready_i = 1'b1;
    #1;
    check("lw_rd_c", {30'd0, mem_read_o, i_or_d_o}, 32'd3);
    step_state("lw_st4", 4'd4);
    check("lw_wb", {29'd0, mem_to_reg_o, reg_write_o, reg_dst_o}, 32'd6);
    step_state("lw_st0", 4'd0);

    // beq: taken then not-taken in the same BRANCH cycle (Mealy output).
    opcode_i = 6'h04;
    zero_i   = 1'b1;
    step_state("beq_st1", 4'd1);
    step_state("beq_st10", 4'd10);
    check("beq_z1_pcw", {31'd0, pc_write_o}, 32'd1);
    check("beq_pcsrc", {30'd0, pc_source_o}, 32'd1);
    check("beq_aluop", {29'd0, alu_op_o}, 32'd1);
    zero_i = 1'b0;
    #1;
    check("beq_z0_pcw", {31'd0, pc_write_o}, 32'd0);
    step_state("beq_st0", 4'd0);

    // bne: inverted sense.
    opcode_i = 6'h05;
    zero_i   = 1'b1;
    step_state("bne_st1", 4'd1);
    step_state("bne_st10", 4'd10);
    check("bne_z1_pcw", {31'd0, pc_write_o}, 32'd0);
    zero_i = 1'b0;
    #1;
    check("bne_z0_pcw", {31'd0, pc_write_o}, 32'd1);
    step_state("bne_st0", 4'd0);

    // ori: 0,1,8,9,0
    opcode_i = 6'h0D;
    step_state("ori_st1", 4'd1);
    step_state("ori_st8", 4'd8);
    check("ori_aluop", {29'd0, alu_op_o}, 32'd3);
    check("ori_srcb", {30'd0, alu_src_b_o}, 32'd2);
    step_state("ori_st9", 4'd9);
    check("ori_wb", {30'd0, reg_write_o, reg_dst_o}, 32'd2);
    step_state("ori_st0", 4'd0);

    // andi: ALU op select in EXEC_I.
    opcode_i = 6'h0C;
    step_state("andi_st1", 4'd1);
    step_state("andi_st8", 4'd8);
    check("andi_aluop", {29'd0, alu_op_o}, 32'd4);
    step_state("andi_st9", 4'd9);
    step_state("andi_st0", 4'd0);

    // j: 0,1,11,0
    opcode_i = 6'h02;
    step_state("j_st1", 4'd1);
    step_state("j_st11", 4'd11);
    check("j_pcw_src", {29'd0, pc_write_o, pc_source_o}, 32'd6);
    step_state("j_st0", 4'd0);

    // Illegal opcode: one-cycle pulse in DECODE, straight back to FETCH.
    opcode_i = 6'h3F;
    check("ill_fetch", {31'd0, illegal_o}, 32'd0);
    step_state("ill_st1", 4'd1);
    check("ill_pulse", {31'd0, illegal_o}, 32'd1);
    no_writes("ill_writes");
    step_state("ill_st0", 4'd0);
    check("ill_after", {31'd0, illegal_o}, 32'd0);

    // sw with reset asserted asynchronously during MEM_WRITE.
    opcode_i = 6'h2B;
    step_state("sw_st1", 4'd1);
    step_state("sw_st2", 4'd2);
    mem_ready_i = 1'b0;
    step_state("sw_st5", 4'd5);
    check("sw_memw", {30'd0, mem_write_o, i_or_d_o}, 32'd3);
    step_state("sw_hold5", 4'd5);
    #2;
    reset = 1'b1;
    #1;
    check("sw_rst_state", {28'd0, state_o}, 32'd0);
    check("sw_rst_memw", {31'd0, mem_write_o}, 32'd0);
    mem_ready_i = 1'b1;
    #1;
    no_writes("sw_rst_writes");
    @(negedge clk);
    reset = 1'b0;
    step_state("post_rst_st1", 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencing controller for the MIPS core. It replaces the single-cycle combinational control so that the program memory, data memory and a single ALU can be shared across cycles of one instruction. The block is a state machine driven by the opcode latched in the instruction register and the ALU zero flag, and it supports memory wait states through a ready handshake. It drives every enable and mux select of the multi-cycle datapath: PC, IR, register file, ALU source muxes and memory.

## Interface
Parameters:
- none. Opcodes, state codes and alu_op codes are package constants.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; forces state FETCH
- opcode_i  in  6  instruction register [31:26], valid from DECODE onward
- zero_i  in  1  ALU zero flag
- mem_ready_i  in  1  unified memory completes the current read or write this cycle
- pc_write_o  out  1  PC load enable (already combined with the branch condition)
- ir_write_o  out  1  instruction register load enable
- i_or_d_o  out  1  memory address select: 0 = PC, 1 = ALU_OUT
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- mem_to_reg_o  out  1  register write-data select: 0 = ALU_OUT, 1 = MDR
- reg_dst_o  out  1  write-register select: 0 = rt, 1 = rd
- reg_write_o  out  1  register file write enable
- alu_src_a_o  out  1  0 = PC, 1 = A register
- alu_src_b_o  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2
- alu_op_o  out  3  000 add, 001 sub, 010 funct-decoded, 011 or, 100 and
- pc_source_o  out  2  00 = ALU result, 01 = ALU_OUT, 10 = jump target
- state_o  out  4  current state code, for debug
- illegal_o  out  1  one-cycle pulse in DECODE on an unsupported opcode

## Operation
Supported opcodes:
- R-type 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B.

States and transitions:
- FETCH: i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00.
  - While mem_ready_i=0, hold in FETCH with ir_write=pc_write=0.
  - When mem_ready_i=1, assert ir_write=1 and pc_write=1, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=add (branch target into ALU_OUT). Next state by opcode:
  - lw or sw → MEM_ADDR
  - R-type → EXEC_R
  - addi, andi or ori → EXEC_I
  - beq or bne → BRANCH
  - j → JUMP
  - any other opcode → FETCH, with illegal_o=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=add. Next: lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: i_or_d=1, mem_read=1. Hold until mem_ready_i=1, then go to MEM_WB.
- MEM_WRITE: i_or_d=1, mem_write=1. Hold until mem_ready_i=1, then go to FETCH.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=010, then WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op = add for addi, and for andi, or for ori. Then WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_source=01.
  - pc_write = zero_i for beq, ~zero_i for bne. This is the only Mealy output.
  - Next: FETCH.
- JUMP: pc_source=10, pc_write=1, then FETCH.

Output defaults:
- Any output not listed for a state is 0.
- opcode_i is sampled only in DECODE, MEM_ADDR, EXEC_I and BRANCH. The IR is stable in those states.

## Timing
Reset:
- State is FETCH asynchronously.
- While reset=1, pc_write, ir_write, reg_write, mem_write and illegal are forced to 0. The other outputs take their FETCH values.

Latency with zero wait states:
- branch and jump: 3 cycles
- R-type, I-type ALU and sw: 4 cycles
- lw: 5 cycles
- Each cycle with mem_ready_i=0 adds one cycle in FETCH, MEM_READ or MEM_WRITE.

Handshake:
- mem_read_o and mem_write_o stay asserted and stable until the cycle in which mem_ready_i=1.
- mem_ready_i is ignored outside the three memory states.

Reset mid-instruction:
- The state machine aborts to FETCH immediately.
- No write enable may glitch high during reset.

## Structure
- Shared package mips_pkg holds:
  - opcode localparams
  - 4-bit state codes: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXEC_R=6, WB_R=7, EXEC_I=8, WB_I=9, BRANCH=10, JUMP=11
  - alu_op and alu_src_b encodings, shared with ALU_Control
- One natural sub-module: multicycle_output_decode, a pure combinational map from (state, opcode, zero_i, mem_ready_i) to all outputs.
- The state register and next-state logic stay in the top module.

## Test plan
- Reset held, then released with opcode_i=0x00 and mem_ready_i=1:
  - During reset: state_o=0, pc_write=0.
  - After release: state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7.
- lw (0x23) with mem_ready_i low for 2 cycles in MEM_READ:
  - States 0,1,2,3,3,3,4,0.
  - mem_read=1 and i_or_d=1 held throughout state 3.
  - mem_to_reg=1 in state 4.
- Branches:
  - beq with zero_i=1 → pc_write=1 and pc_source=01 in BRANCH.
  - beq with zero_i=0 → pc_write=0.
  - bne inverts both cases.
- ori (0x0D):
  - alu_op=011 and alu_src_b=10 in EXEC_I.
  - reg_write=1 and reg_dst=0 in WB_I.
  - Total 4 cycles.
- Illegal opcode 0x3F: illegal_o is a one-cycle pulse in DECODE, the next state is FETCH, and no write enable is asserted.
- Reset asserted asynchronously in MEM_WRITE with mem_write=1: mem_write drops in the same cycle and state_o=0.
